destuff_crc_block: RTL and testbench

Receive-path stage directly upstream of `error_overload_block` in the CAN controller. It consumes the bit sampled on each sample point, removes stuff bits, and detects stuff violations (six equal consecutive bits). It accumulates the CAN CRC-15 over the frame and compares it against the received CRC sequence. Its `stuffErro` and `crcErro` outputs feed `error_overload_block` directly. Destuffed bits go to the frame decoder, which in turn drives this block's window strobes.

---
 rtl/can_pkg.sv | 29 ++
 rtl/can_crc15.sv | 29 ++
 rtl/destuff_crc_block.sv | 129 ++++++++++++
 tb/tb_destuff_crc_block.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
// Shared CAN receive-path constants, bit classification and CRC-15 step.
package can_pkg;

  localparam int               CRC_W         = 15;
  localparam logic [CRC_W-1:0] CAN_CRC_POLY  = 15'h4599;
  localparam int               CAN_STUFF_LEN = 5;
  localparam logic             ERR_IDLE      = 1'b1;

  // How the bit sampled on the current edge is treated by the destuffer.
  typedef enum logic [2:0] {
    ACT_PASS,
    ACT_SOF,
    ACT_DATA,
    ACT_STUFF,
    ACT_ERROR,
    ACT_LOCKED
  } bit_act_e;

  function automatic logic [CRC_W-1:0] crc15_step(
    input logic [CRC_W-1:0] crc,
    input logic             din,
    input logic [CRC_W-1:0] poly
  );
    logic n;
    n = din ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (n ? poly : '0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// CAN CRC-15 shift/xor register; clr and en on the same edge restarts from zero.
module can_crc15
  import can_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CAN_CRC_POLY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic [CRC_W-1:0] base;

  assign base = clr ? '0 : crc;

  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= '0;
    end else if (en) begin
      crc <= crc15_step(base, din, POLY);
    end else if (clr) begin
      crc <= '0;
    end
  end

endmodule

// File: rtl/destuff_crc_block.sv
// CAN receive-path destuffer with stuff-violation detection and CRC-15 check.
// stuffErro / crcErro are active-low, one-cycle pulses.
module destuff_crc_block
  import can_pkg::*;
#(
  parameter logic [CRC_W-1:0] CRC_POLY  = CAN_CRC_POLY,
  parameter int               STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic             samplePoint,
  input  logic             reset,
  input  logic             rxBit,
  input  logic             stuffEnable,
  input  logic             crcEnable,
  input  logic             crcCheck,
  input  logic             crcEnd,
  output logic             dataBit,
  output logic             dataValid,
  output logic             stuffErro,
  output logic             crcErro,
  output logic [CRC_W-1:0] crcReg
);

  localparam logic [2:0] STUFF_RUN = 3'(STUFF_LEN);

  logic             last_bit;
  logic [2:0]       run_len;
  logic             stuff_lock;
  logic             prev_stuff_en;
  logic [CRC_W-1:0] rx_crc;

  bit_act_e act;
  logic     sof;
  logic     bit_valid;
  logic     crc_en;
  logic     rx_shift;

  // SOF outranks the lock so a fresh frame always recovers from a stuff error.
  always_comb begin
    sof = stuffEnable & ~prev_stuff_en;
    act = ACT_DATA;
    if (sof) begin
      act = ACT_SOF;
    end else if (stuff_lock) begin
      act = ACT_LOCKED;
    end else if (!stuffEnable) begin
      act = ACT_PASS;
    end else if (run_len == STUFF_RUN) begin
      act = (rxBit == last_bit) ? ACT_ERROR : ACT_STUFF;
    end
  end

  assign bit_valid = (act == ACT_SOF) || (act == ACT_DATA) || (act == ACT_PASS);
  assign crc_en    = bit_valid & crcEnable & ~crcCheck;
  assign rx_shift  = bit_valid & crcCheck;

  can_crc15 #(
    .POLY (CRC_POLY)
  ) u_crc (
    .clk   (samplePoint),
    .reset (reset),
    .clr   (sof),
    .en    (crc_en),
    .din   (rxBit),
    .crc   (crcReg)
  );

  always_ff @(posedge samplePoint) begin
    if (reset) begin
      dataBit       <= 1'b1;
      dataValid     <= 1'b0;
      stuffErro     <= ERR_IDLE;
      crcErro       <= ERR_IDLE;
      last_bit      <= 1'b1;
      run_len       <= '0;
      stuff_lock    <= 1'b0;
      prev_stuff_en <= 1'b0;
      rx_crc        <= '0;
    end else begin
      prev_stuff_en <= stuffEnable;
      dataBit       <= rxBit;
      dataValid     <= bit_valid;
      stuffErro     <= (act == ACT_ERROR) ? ~ERR_IDLE : ERR_IDLE;
      // The compare sees the pre-edge registers; a locked frame already reported.
      crcErro       <= (crcEnd && !stuff_lock && (rx_crc != crcReg)) ? ~ERR_IDLE : ERR_IDLE;

      case (act)
        ACT_SOF: begin
          stuff_lock <= 1'b0;
          run_len    <= 3'd1;
          last_bit   <= rxBit;
        end
        ACT_DATA: begin
          if (rxBit == last_bit) begin
            run_len <= run_len + 3'd1;
          end else begin
            run_len  <= 3'd1;
            last_bit <= rxBit;
          end
        end
        ACT_STUFF: begin
          run_len  <= 3'd1;
          last_bit <= rxBit;
        end
        ACT_ERROR: begin
          run_len    <= '0;
          stuff_lock <= 1'b1;
        end
        ACT_PASS: begin
          run_len <= '0;
        end
        ACT_LOCKED: begin
          if (!stuffEnable) begin
            run_len <= '0;
          end
        end
        default: begin
          run_len <= '0;
        end
      endcase

      if (sof) begin
        rx_crc <= rx_shift ? {{(CRC_W-1){1'b0}}, rxBit} : '0;
      end else if (rx_shift) begin
        rx_crc <= {rx_crc[CRC_W-2:0], rxBit};
      end
    end
  end

endmodule

// File: tb/tb_destuff_crc_block.sv
// Bench for destuff_crc_block: directed vector table, corner sequences, random frames vs model.
module tb_destuff_crc_block;

  logic        samplePoint = 1'b0;
  logic        reset       = 1'b1;
  logic        rxBit       = 1'b1;
  logic        stuffEnable = 1'b0;
  logic        crcEnable   = 1'b0;
  logic        crcCheck    = 1'b0;
  logic        crcEnd      = 1'b0;
  logic        dataBit;
  logic        dataValid;
  logic        stuffErro;
  logic        crcErro;
  logic [14:0] crcReg;

  int n_cmp = 0;
  int n_bad = 0;

  destuff_crc_block dut (
    .samplePoint (samplePoint),
    .reset       (reset),
    .rxBit       (rxBit),
    .stuffEnable (stuffEnable),
    .crcEnable   (crcEnable),
    .crcCheck    (crcCheck),
    .crcEnd      (crcEnd),
    .dataBit     (dataBit),
    .dataValid   (dataValid),
    .stuffErro   (stuffErro),
    .crcErro     (crcErro),
    .crcReg      (crcReg)
  );

  always #5 samplePoint = ~samplePoint;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst, rx, se, ce, cc, cend;
    logic        ev, es, ec, chk;
    logic [14:0] ecrc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, rx, se, ce, cc, cend, ev, es, ec, chk,
                              input logic [14:0] ecrc);
    vec_t v;
    v.rst = rst; v.rx = rx; v.se = se; v.ce = ce; v.cc = cc; v.cend = cend;
    v.ev = ev; v.es = es; v.ec = ec; v.chk = chk; v.ecrc = ecrc;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [14:0] got, input logic [14:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic apply(input logic rst, rx, se, ce, cc, cend);
    @(negedge samplePoint);
    reset = rst; rxBit = rx; stuffEnable = se;
    crcEnable = ce; crcCheck = cc; crcEnd = cend;
    @(posedge samplePoint);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    apply(v.rst, v.rx, v.se, v.ce, v.cc, v.cend);
    cmp({tag, ".dataValid"}, dataValid, v.ev);
    cmp({tag, ".stuffErro"}, stuffErro, v.es);
    cmp({tag, ".crcErro"}, crcErro, v.ec);
    cmp({tag, ".dataBit"}, dataBit, v.rst ? 1'b1 : v.rx);
    if (v.chk) cmp({tag, ".crcReg"}, crcReg, v.ecrc);
  endtask

  // ---------------- reference model (frame-level view) ----------------
  bit m_prev_se, m_lock;
  bit hist[$];     // bits since SOF that count toward the stuff rule
  bit crc_msg[$];  // frame bits that enter the CRC
  bit rx_hist[$];  // received CRC-sequence bits
  logic e_bit, e_valid, e_serr, e_cerr;
  logic [14:0] e_crc;

  // Remainder of M(x)*x^15 divided by the full generator x^15 + 0x4599.
  function automatic logic [14:0] div_crc(input bit msg[$]);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < msg.size() + 15; i++) begin
      r = {r[14:0], (i < msg.size()) ? msg[i] : 1'b0};
      if (r[15]) r = r ^ 16'hC599;
    end
    return r[14:0];
  endfunction

  function automatic logic [14:0] rx_pack();
    logic [14:0] v;
    v = '0;
    foreach (rx_hist[i]) v = {v[13:0], rx_hist[i]};
    return v;
  endfunction

  function automatic int trailing_run();
    int n;
    n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size() - 1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step(input bit rst, rx, se, ce, cc, cend);
    bit sof, valid;
    if (rst) begin
      m_prev_se = 0; m_lock = 0;
      hist.delete(); crc_msg.delete(); rx_hist.delete();
      e_bit = 1; e_valid = 0; e_serr = 1; e_cerr = 1; e_crc = '0;
      return;
    end
    e_bit  = rx;
    e_serr = 1;
    e_cerr = (cend && !m_lock && rx_pack() != div_crc(crc_msg)) ? 1'b0 : 1'b1;
    sof    = se && !m_prev_se;
    valid  = 0;
    if (sof) begin
      m_lock = 0;
      hist.delete(); crc_msg.delete(); rx_hist.delete();
      hist.push_back(rx);
      valid = 1;
    end else if (m_lock) begin
      valid = 0;
    end else if (!se) begin
      hist.delete();
      valid = 1;
    end else if (trailing_run() == 5) begin
      if (rx != hist[hist.size() - 1]) begin
        hist.push_back(rx);
      end else begin
        e_serr = 0;
        m_lock = 1;
        hist.delete();
      end
    end else begin
      hist.push_back(rx);
      valid = 1;
    end
    if (valid && cc) rx_hist.push_back(rx);
    else if (valid && ce) crc_msg.push_back(rx);
    m_prev_se = se;
    e_valid   = valid;
    e_crc     = div_crc(crc_msg);
  endtask

  task automatic rnd_edge(input bit rst, rx, se, ce, cc, cend);
    model_step(rst, rx, se, ce, cc, cend);
    apply(rst, rx, se, ce, cc, cend);
    cmp("rnd.dataValid", dataValid, e_valid);
    cmp("rnd.stuffErro", stuffErro, e_serr);
    cmp("rnd.crcErro", crcErro, e_cerr);
    cmp("rnd.dataBit", dataBit, e_bit);
    cmp("rnd.crcReg", crcReg, e_crc);
  endtask

  logic        sr_bits[7] = '{0, 0, 0, 0, 0, 1, 1};
  logic        sr_val[7]  = '{1, 1, 1, 1, 1, 0, 1};
  logic [14:0] pat;
  logic [14:0] fcrc;
  bit          five_ones[$];

  initial begin
    // ---------------- directed table ----------------
    repeat (3) vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 15'h0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, sr_bits[i], 1, 0, 0, 0, sr_val[i], 1, 1, 1, 15'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 15'h0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, (i < 5), (i != 5), 1, 1, 15'h0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 15'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 15'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 15'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 15'h0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 15'h0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 15'h0));
    // CRC pass then CRC fail (received bit 7 flipped)
    for (int pass = 0; pass < 2; pass++) begin
      pat = (pass == 0) ? 15'h4599 : (15'h4599 ^ 15'h0080);
      if (pass == 1) vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 15'h0));
      vecs.push_back(mk(0, 1, 0, 1, 0, 0, 1, 1, 1, 1, 15'h4599));
      for (int i = 14; i >= 0; i--)
        vecs.push_back(mk(0, pat[i], 0, 0, 1, 0, 1, 1, 1, 1, 15'h4599));
      vecs.push_back(mk(0, 1, 0, 0, 0, 1, 1, 1, (pass == 0), 1, 15'h4599));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 15'h4599));
    end
    // reset mid-frame: 3 + reset + 3 equal bits, no stuff drop or error
    repeat (3) vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 15'h0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1, 1, 1, 15'h0));
    repeat (3) vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 15'h0));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("tbl%0d", i));

    // ---------------- corner: crcEnable and crcCheck together ----------------
    apply(1, 1, 0, 0, 0, 0);
    apply(0, 1, 0, 1, 0, 0);
    cmp("both.crc_after_data", crcReg, 15'h4599);
    apply(0, 1, 0, 1, 1, 0);
    cmp("both.crc_frozen", crcReg, 15'h4599);
    apply(0, 1, 0, 0, 0, 1);
    cmp("both.crcErro_mismatch", crcErro, 1'b0);

    // ---------------- corner: crcEnd ignored while locked ----------------
    repeat (5) five_ones.push_back(1'b1);
    apply(1, 1, 0, 0, 0, 0);
    repeat (5) apply(0, 1, 1, 1, 0, 0);
    cmp("lock.pre_err", stuffErro, 1'b1);
    apply(0, 1, 1, 1, 0, 0);
    cmp("lock.stuffErro", stuffErro, 1'b0);
    cmp("lock.valid_on_err", dataValid, 1'b0);
    cmp("lock.crc_no_err_bit", crcReg, div_crc(five_ones));
    apply(0, 1, 1, 1, 0, 1);
    cmp("lock.crcEnd_ignored", crcErro, 1'b1);
    cmp("lock.stuffErro_one_cycle", stuffErro, 1'b1);
    cmp("lock.crc_frozen", crcReg, div_crc(five_ones));
    cmp("lock.valid", dataValid, 1'b0);

    // ---------------- corner: stuffEnable drop mid-run ----------------
    apply(1, 1, 0, 0, 0, 0);
    repeat (4) apply(0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0);
    cmp("drop.pass_valid", dataValid, 1'b1);
    cmp("drop.no_err", stuffErro, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply(0, 0, 1, 0, 0, 0);
      cmp($sformatf("drop.run%0d_valid", i), dataValid, 1'b1);
      cmp($sformatf("drop.run%0d_noerr", i), stuffErro, 1'b1);
    end
    apply(0, 0, 1, 0, 0, 0);
    cmp("drop.sixth_err", stuffErro, 1'b0);

    // ---------------- randomized frames vs model ----------------
    rnd_edge(1, 1, 0, 0, 0, 0);
    for (int f = 0; f < 40; f++) begin
      bit good, both, cur, b, in_crc;
      int nd, flip_w, sent;
      good   = $urandom_range(0, 1);
      both   = ($urandom_range(0, 3) == 0);
      nd     = $urandom_range(1, 24);
      flip_w = $urandom_range(2, 5);
      cur    = $urandom_range(0, 1);
      repeat ($urandom_range(1, 3)) rnd_edge(0, $urandom_range(0, 1), 0, 0, 0, 0);
      if ($urandom_range(0, 9) == 0) rnd_edge(1, 1, 0, 0, 0, 0);
      sent = 0;
      while (sent < nd + 15) begin
        in_crc = (sent >= nd);
        if (good && m_prev_se && !m_lock && trailing_run() == 5) begin
          b = !hist[hist.size() - 1];
        end else begin
          if (good && in_crc) begin
            fcrc = div_crc(crc_msg);
            b = fcrc[14 - (sent - nd)];
          end else if (good) begin
            b = $urandom_range(0, 1);
          end else begin
            if ($urandom_range(1, flip_w) == 1) cur = !cur;
            b = cur;
          end
          sent++;
        end
        rnd_edge(0, b, 1, !in_crc || both, in_crc, 0);
      end
      rnd_edge(0, 1, 0, 0, 0, 1);
      rnd_edge(0, 1, 0, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
